sram_like_axi_bridge: RTL and testbench

- Converts the core's two sram-like ports (inst, data) into one AXI3 master. Sits directly downstream of the CPU top and upstream of the SoC AXI interconnect.
- Arbitrates the two ports and allows one outstanding transaction at a time.
- Returns rdata and the data_ok pulse to the port that issued the transaction.

---
 rtl/sram_like_axi_bridge_pkg.sv | 34 +++
 rtl/sram_like_axi_bridge_if.sv | 86 ++++++++
 rtl/sram_like_axi_bridge.sv | 145 ++++++++++++++
 tb/tb_sram_like_axi_bridge.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_axi_bridge_pkg.sv
// Shared types and helpers for the sram-like to AXI3 bridge.
// Optional feature macro used by this slice: BRIDGE_RESP_CHK_EN.
package bridge_pkg;

   typedef enum logic [2:0] {
      IDLE,
      AR,
      R,
      AW_W,
      B
   } state_e;

   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } owner_e;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   // Byte lanes touched by an access; the illegal size 3 falls back to a full word.
   function automatic logic [3:0] size_addr_to_wstrb(input logic [1:0] size,
                                                     input logic [1:0] addr_lo);
      logic [3:0] strb;
      case (size)
         SIZE_BYTE: strb = 4'b0001 << addr_lo;
         SIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
         default:   strb = 4'b1111;
      endcase
      return strb;
   endfunction

endpackage

// File: rtl/sram_like_axi_bridge_if.sv
// Bus bundle for the bridge: both sram-like core ports plus the AXI3 master channels.
// With BRIDGE_RESP_CHK_EN defined, adds rresp/bresp and the sticky bus_err flag.
interface sram_like_axi_bridge_if;

   logic        inst_req;
   logic        inst_wr;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr;
   logic [31:0] inst_wdata;
   logic [31:0] inst_rdata;
   logic        inst_addr_ok;
   logic        inst_data_ok;

   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        data_addr_ok;
   logic        data_data_ok;

   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [2:0]  arsize;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic        rvalid;
   logic        rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [2:0]  awsize;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic        bvalid;
   logic        bready;
`ifdef BRIDGE_RESP_CHK_EN
   logic [1:0]  rresp;
   logic [1:0]  bresp;
   logic        bus_err;
`endif

   // Bridge side: serves the core ports, masters the AXI bus.
   modport master (
      input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
      output inst_rdata, inst_addr_ok, inst_data_ok,
      input  data_req, data_wr, data_size, data_addr, data_wdata,
      output data_rdata, data_addr_ok, data_data_ok,
      output arid, araddr, arsize, arvalid,
      input  arready, rdata, rvalid,
      output rready, awid, awaddr, awsize, awvalid,
      input  awready,
      output wdata, wstrb, wvalid,
      input  wready, bvalid,
      output bready
`ifdef BRIDGE_RESP_CHK_EN
      , input rresp, bresp
      , output bus_err
`endif
   );

   // Environment side: core ports and AXI slave.
   modport slave (
      output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
      input  inst_rdata, inst_addr_ok, inst_data_ok,
      output data_req, data_wr, data_size, data_addr, data_wdata,
      input  data_rdata, data_addr_ok, data_data_ok,
      input  arid, araddr, arsize, arvalid,
      output arready, rdata, rvalid,
      input  rready, awid, awaddr, awsize, awvalid,
      output awready,
      input  wdata, wstrb, wvalid,
      output wready, bvalid,
      input  bready
`ifdef BRIDGE_RESP_CHK_EN
      , output rresp, bresp
      , input bus_err
`endif
   );

endinterface

// File: rtl/sram_like_axi_bridge.sv
// Arbitrates the inst and data sram-like ports onto a single AXI3 master,
// one outstanding transaction at a time; data port wins ties.
// Optional macro BRIDGE_RESP_CHK_EN adds a sticky bus_err on non-OKAY responses.
module sram_like_axi_bridge
   import bridge_pkg::*;
#(
   parameter logic [3:0] INST_ID = 4'd0,
   parameter logic [3:0] DATA_ID = 4'd1
) (
   input logic                    clk,
   input logic                    resetn,
   sram_like_axi_bridge_if.master bus
);

   state_e      state_q, state_d;
   owner_e      owner_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        aw_done_q;
   logic        w_done_q;

   logic        grant;
   owner_e      grant_owner;
   logic [1:0]  grant_size;
   logic [31:0] grant_addr;
   logic [31:0] grant_wdata;
   logic        resp_done;

   // Next-state, grant and handshake outputs.
   always_comb begin
      state_d          = state_q;
      grant            = 1'b0;
      grant_owner      = OWN_DATA;
      resp_done        = 1'b0;
      bus.inst_addr_ok = 1'b0;
      bus.data_addr_ok = 1'b0;
      bus.arvalid      = 1'b0;
      bus.rready       = 1'b0;
      bus.awvalid      = 1'b0;
      bus.wvalid       = 1'b0;
      bus.bready       = 1'b0;
      case (state_q)
         IDLE: begin
            // Grants are suppressed while reset is held so addr_ok stays low.
            if (resetn && bus.data_req) begin
               grant            = 1'b1;
               grant_owner      = OWN_DATA;
               bus.data_addr_ok = 1'b1;
               state_d          = bus.data_wr ? AW_W : AR;
            end else if (resetn && bus.inst_req) begin
               grant            = 1'b1;
               grant_owner      = OWN_INST;
               bus.inst_addr_ok = 1'b1;
               state_d          = bus.inst_wr ? AW_W : AR;
            end
         end
         AR: begin
            bus.arvalid = 1'b1;
            if (bus.arready) state_d = R;
         end
         R: begin
            bus.rready = 1'b1;
            if (bus.rvalid) begin
               resp_done = 1'b1;
               state_d   = IDLE;
            end
         end
         AW_W: begin
            bus.awvalid = !aw_done_q;
            bus.wvalid  = !w_done_q;
            if ((aw_done_q || bus.awready) && (w_done_q || bus.wready)) state_d = B;
         end
         B: begin
            bus.bready = 1'b1;
            if (bus.bvalid) begin
               resp_done = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign grant_size  = (grant_owner == OWN_DATA) ? bus.data_size  : bus.inst_size;
   assign grant_addr  = (grant_owner == OWN_DATA) ? bus.data_addr  : bus.inst_addr;
   assign grant_wdata = (grant_owner == OWN_DATA) ? bus.data_wdata : bus.inst_wdata;

   // State register, request latch and per-channel write handshake tracking.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= IDLE;
         owner_q   <= OWN_INST;
         size_q    <= SIZE_BYTE;
         addr_q    <= '0;
         wdata_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            owner_q   <= grant_owner;
            size_q    <= grant_size;
            addr_q    <= grant_addr;
            wdata_q   <= grant_wdata;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
         end else if (state_q == AW_W) begin
            if (bus.awready) aw_done_q <= 1'b1;
            if (bus.wready)  w_done_q  <= 1'b1;
         end
      end
   end

   assign bus.inst_data_ok = resp_done && (owner_q == OWN_INST);
   assign bus.data_data_ok = resp_done && (owner_q == OWN_DATA);
   assign bus.inst_rdata   = (state_q == R && owner_q == OWN_INST) ? bus.rdata : '0;
   assign bus.data_rdata   = (state_q == R && owner_q == OWN_DATA) ? bus.rdata : '0;

   assign bus.arid   = (owner_q == OWN_DATA) ? DATA_ID : INST_ID;
   assign bus.awid   = (owner_q == OWN_DATA) ? DATA_ID : INST_ID;
   assign bus.araddr = addr_q;
   assign bus.awaddr = addr_q;
   assign bus.arsize = {1'b0, size_q};
   assign bus.awsize = {1'b0, size_q};
   assign bus.wdata  = wdata_q;
   assign bus.wstrb  = size_addr_to_wstrb(size_q, addr_q[1:0]);

`ifdef BRIDGE_RESP_CHK_EN
   logic bus_err_q;

   // Sticky error on any completing handshake with a non-OKAY response.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         bus_err_q <= 1'b0;
      end else if ((state_q == R && bus.rvalid && bus.rresp != 2'b00) ||
                   (state_q == B && bus.bvalid && bus.bresp != 2'b00)) begin
         bus_err_q <= 1'b1;
      end
   end

   assign bus.bus_err = bus_err_q;
`endif

endmodule

// File: tb/tb_sram_like_axi_bridge.sv
// Scoreboard bench for sram_like_axi_bridge: directed requests push expected AXI
// address/write beats and port responses; a negedge monitor pops and compares.
module tb_sram_like_axi_bridge;
   import bridge_pkg::*;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   sram_like_axi_bridge_if bus ();

   sram_like_axi_bridge #(
      .INST_ID (4'd0),
      .DATA_ID (4'd1)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   typedef struct {logic owner; logic is_rd; logic [31:0] rdata;} resp_t;
   typedef struct {logic [31:0] addr; logic [3:0] id; logic [2:0] size;} addr_t;
   typedef struct {logic [31:0] data; logic [3:0] strb;} wbeat_t;

   resp_t  resp_q[$];
   addr_t  ar_q[$];
   addr_t  aw_q[$];
   wbeat_t w_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int accept_cyc = 0;
   int done_cyc = 0;

   int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
   logic [31:0] r_val = '0;
   logic [1:0]  r_resp = 2'b00, b_resp = 2'b00;
   int          ar_c = 0, r_c = 0, aw_c = 0, w_c = 0, b_c = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event missing or unexpected", name);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // AXI slave with per-channel ready/valid delays counted from the valid/ready cycle.
   initial begin
      bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
      bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
`ifdef BRIDGE_RESP_CHK_EN
      bus.rresp = 2'b00; bus.bresp = 2'b00;
`endif
      forever begin
         @(posedge clk);
         #2;
         if (!resetn) begin
            ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
            bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
            bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
         end else begin
            ar_c = bus.arvalid ? ar_c + 1 : 0;
            r_c  = bus.rready  ? r_c + 1  : 0;
            aw_c = bus.awvalid ? aw_c + 1 : 0;
            w_c  = bus.wvalid  ? w_c + 1  : 0;
            b_c  = bus.bready  ? b_c + 1  : 0;
            bus.arready = bus.arvalid && (ar_c > ar_wait);
            bus.rvalid  = bus.rready  && (r_c > r_wait);
            bus.rdata   = bus.rvalid ? r_val : 32'h0;
            bus.awready = bus.awvalid && (aw_c > aw_wait);
            bus.wready  = bus.wvalid  && (w_c > w_wait);
            bus.bvalid  = bus.bready  && (b_c > b_wait);
         end
`ifdef BRIDGE_RESP_CHK_EN
         bus.rresp = bus.rvalid ? r_resp : 2'b00;
         bus.bresp = bus.bvalid ? b_resp : 2'b00;
`endif
      end
   end

   resp_t  m_r;
   addr_t  m_a;
   wbeat_t m_w;

   // Monitor: compare every handshake and response against the scoreboard.
   always @(negedge clk) begin
      if (resetn) begin
         if (bus.arvalid && bus.arready) begin
            if (ar_q.size() == 0) fail("ar_unexpected");
            else begin
               m_a = ar_q.pop_front();
               chk("araddr", bus.araddr, m_a.addr);
               chk("arid", 32'(bus.arid), 32'(m_a.id));
               chk("arsize", 32'(bus.arsize), 32'(m_a.size));
            end
         end
         if (bus.awvalid && bus.awready) begin
            if (aw_q.size() == 0) fail("aw_unexpected");
            else begin
               m_a = aw_q.pop_front();
               chk("awaddr", bus.awaddr, m_a.addr);
               chk("awid", 32'(bus.awid), 32'(m_a.id));
               chk("awsize", 32'(bus.awsize), 32'(m_a.size));
            end
         end
         if (bus.wvalid && bus.wready) begin
            if (w_q.size() == 0) fail("w_unexpected");
            else begin
               m_w = w_q.pop_front();
               chk("wdata", bus.wdata, m_w.data);
               chk("wstrb", 32'(bus.wstrb), 32'(m_w.strb));
            end
         end
         if (bus.inst_data_ok || bus.data_data_ok) begin
            done_cyc = cyc;
            if (resp_q.size() == 0) fail("data_ok_unexpected");
            else begin
               m_r = resp_q.pop_front();
               chk("data_ok_port", 32'({bus.data_data_ok, bus.inst_data_ok}),
                   m_r.owner ? 32'd2 : 32'd1);
               if (m_r.is_rd)
                  chk("rdata", m_r.owner ? bus.data_rdata : bus.inst_rdata, m_r.rdata);
            end
         end
      end
   end

   task automatic drive_port(input logic port, input logic req, input logic wr,
                             input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wd);
      if (port) begin
         bus.data_req = req; bus.data_wr = wr; bus.data_size = size;
         bus.data_addr = addr; bus.data_wdata = wd;
      end else begin
         bus.inst_req = req; bus.inst_wr = wr; bus.inst_size = size;
         bus.inst_addr = addr; bus.inst_wdata = wd;
      end
   endtask

   task automatic push_exp(input logic port, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] e_id,
                           input logic [2:0] e_size, input logic [3:0] e_strb,
                           input logic [31:0] e_rdata);
      resp_t  r;
      addr_t  a;
      wbeat_t w;
      r.owner = port; r.is_rd = !wr; r.rdata = e_rdata;
      a.addr = addr; a.id = e_id; a.size = e_size;
      w.data = wd; w.strb = e_strb;
      resp_q.push_back(r);
      if (wr) begin
         aw_q.push_back(a);
         w_q.push_back(w);
      end else begin
         ar_q.push_back(a);
      end
   endtask

   // Present one request, wait for its addr_ok, record expectations, then drop it.
   task automatic issue(input logic port, input logic wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] e_id, input logic [2:0] e_size,
                        input logic [3:0] e_strb, input logic [31:0] e_rdata);
      bit ok = 1'b0;
      @(posedge clk);
      #1;
      drive_port(port, 1'b1, wr, size, addr, wd);
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (port ? bus.data_addr_ok : bus.inst_addr_ok) ok = 1'b1;
      end
      if (!ok) fail("addr_ok_timeout");
      else begin
         accept_cyc = cyc;
         push_exp(port, wr, addr, wd, e_id, e_size, e_strb, e_rdata);
      end
      @(posedge clk);
      #1;
      drive_port(port, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
   endtask

   task automatic wait_done(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (resp_q.size() == 0 && ar_q.size() == 0 && aw_q.size() == 0 && w_q.size() == 0)
            ok = 1'b1;
      end
      if (!ok) fail(name);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_outputs(input string name);
      chk(name, 32'({bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready,
                     bus.inst_addr_ok, bus.data_addr_ok, bus.inst_data_ok,
                     bus.data_data_ok}), 32'd0);
      chk({name, "_rdata"}, bus.inst_rdata | bus.data_rdata, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          seen;
      bit          ok;
      logic [4:0]  exp_aw, exp_w, exp_b;

      drive_port(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
      drive_port(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);

      // Reset state, with requests pending so addr_ok must stay low.
      repeat (2) @(posedge clk);
      #1;
      bus.inst_req = 1'b1;
      bus.data_req = 1'b1;
      @(negedge clk);
      chk_idle_outputs("reset_state");
      @(posedge clk);
      #1;
      bus.inst_req = 1'b0;
      bus.data_req = 1'b0;
      resetn = 1'b1;

      // Inst read, arready after 2 wait cycles.
      ar_wait = 2; r_val = 32'h3C1D0000;
      issue(1'b0, 1'b0, SIZE_WORD, 32'hBFC00000, 32'h0, 4'd0, 3'd2, 4'h0, 32'h3C1D0000);
      wait_done("inst_read_done");
      ar_wait = 0;

      // Collision: data wins, inst waits until after data_data_ok.
      r_val = 32'h11223344;
      @(posedge clk);
      #1;
      drive_port(1'b0, 1'b1, 1'b0, SIZE_WORD, 32'hBFC00004, 32'h0);
      drive_port(1'b1, 1'b1, 1'b0, SIZE_WORD, 32'h80000010, 32'h0);
      @(negedge clk);
      chk("coll_data_addr_ok", 32'(bus.data_addr_ok), 32'd1);
      chk("coll_inst_addr_ok", 32'(bus.inst_addr_ok), 32'd0);
      push_exp(1'b1, 1'b0, 32'h80000010, 32'h0, 4'd1, 3'd2, 4'h0, 32'h11223344);
      @(posedge clk);
      #1;
      drive_port(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
      seen = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (bus.inst_addr_ok) begin
            ok = 1'b1;
            chk("coll_inst_after_data", 32'({seen, bus.data_data_ok}), 32'd2);
            r_val = 32'h24020001;
            push_exp(1'b0, 1'b0, 32'hBFC00004, 32'h0, 4'd0, 3'd2, 4'h0, 32'h24020001);
         end
         if (bus.data_data_ok) seen = 1'b1;
      end
      if (!ok) fail("coll_inst_timeout");
      @(posedge clk);
      #1;
      drive_port(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
      wait_done("coll_done");

      // Store strobes across sizes and byte offsets.
      issue(1'b1, 1'b1, SIZE_BYTE, 32'h80000003, 32'h000000AB, 4'd1, 3'd0, 4'b1000, 32'h0);
      wait_done("byte3_done");
      issue(1'b1, 1'b1, SIZE_BYTE, 32'h80000001, 32'h0000CD00, 4'd1, 3'd0, 4'b0010, 32'h0);
      wait_done("byte1_done");
      issue(1'b1, 1'b1, SIZE_HALF, 32'h80000006, 32'hBEEF0000, 4'd1, 3'd1, 4'b1100, 32'h0);
      wait_done("half_hi_done");
      issue(1'b1, 1'b1, SIZE_HALF, 32'h80000004, 32'h0000BEEF, 4'd1, 3'd1, 4'b0011, 32'h0);
      wait_done("half_lo_done");
      issue(1'b1, 1'b1, 2'd3, 32'h8000000C, 32'h12345678, 4'd1, 3'd3, 4'b1111, 32'h0);
      wait_done("size3_done");
      issue(1'b0, 1'b1, SIZE_WORD, 32'h80000100, 32'hCAFEF00D, 4'd0, 3'd2, 4'b1111, 32'h0);
      wait_done("inst_write_done");

      // Minimum latencies: data_ok two cycles after the request cycle.
      r_val = 32'hA5A5_5A5A;
      issue(1'b1, 1'b0, SIZE_WORD, 32'h80000020, 32'h0, 4'd1, 3'd2, 4'h0, 32'hA5A55A5A);
      wait_done("min_rd_done");
      chk("min_rd_latency", 32'(done_cyc - accept_cyc), 32'd2);
      issue(1'b1, 1'b1, SIZE_WORD, 32'h80000024, 32'h0F0F0F0F, 4'd1, 3'd2, 4'b1111, 32'h0);
      wait_done("min_wr_done");
      chk("min_wr_latency", 32'(done_cyc - accept_cyc), 32'd2);

      // Split handshake: awready in cycle 1, wready in cycle 4, then B.
      aw_wait = 0; w_wait = 3; b_wait = 1;
      exp_aw = 5'b00001; exp_w = 5'b01111; exp_b = 5'b10000;
      issue(1'b1, 1'b1, SIZE_WORD, 32'h80000040, 32'h55AA55AA, 4'd1, 3'd2, 4'b1111, 32'h0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("split_awvalid_c%0d", k + 1), 32'(bus.awvalid), 32'(exp_aw[k]));
         chk($sformatf("split_wvalid_c%0d", k + 1), 32'(bus.wvalid), 32'(exp_w[k]));
         chk($sformatf("split_bready_c%0d", k + 1), 32'(bus.bready), 32'(exp_b[k]));
      end
      wait_done("split_done");
      w_wait = 0; b_wait = 0;

      // Reset while in R, one cycle before rvalid would arrive.
      r_wait = 2; r_val = 32'hDEADBEEF;
      issue(1'b1, 1'b0, SIZE_WORD, 32'h80000030, 32'h0, 4'd1, 3'd2, 4'h0, 32'hDEADBEEF);
      @(posedge clk);
      @(posedge clk);
      #1;
      resetn = 1'b0;
      resp_q.delete();
      @(posedge clk);
      #1;
      resetn = 1'b1;
      @(negedge clk);
      chk_idle_outputs("after_mid_reset");
      repeat (4) @(negedge clk);
      r_wait = 0; r_val = 32'h0000_1234;
      issue(1'b1, 1'b0, SIZE_WORD, 32'h80000034, 32'h0, 4'd1, 3'd2, 4'h0, 32'h00001234);
      wait_done("post_reset_read_done");

`ifdef BRIDGE_RESP_CHK_EN
      chk("bus_err_clear", 32'(bus.bus_err), 32'd0);
      b_resp = 2'b10;
      issue(1'b1, 1'b1, SIZE_WORD, 32'h80000050, 32'h1, 4'd1, 3'd2, 4'b1111, 32'h0);
      wait_done("slverr_write_done");
      b_resp = 2'b00;
      chk("bus_err_set", 32'(bus.bus_err), 32'd1);
      r_val = 32'h77;
      issue(1'b1, 1'b0, SIZE_WORD, 32'h80000054, 32'h0, 4'd1, 3'd2, 4'h0, 32'h77);
      wait_done("okay_read_done");
      chk("bus_err_sticky", 32'(bus.bus_err), 32'd1);
      resetn = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      @(negedge clk);
      chk("bus_err_reset", 32'(bus.bus_err), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
